// File: rtl/dmem_arbiter_if.sv
// Two-requester data-memory bus: requester ports plus the memory side.
// The arbiter sits on the slave modport; requesters and memory drive master.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic [ADDR_W-1:0] memAddress;
    logic [DATA_W-1:0] memWriteData;
    logic              memRead;
    logic              memWrite;
    logic [DATA_W-1:0] memReadData;

    modport master (
        output req0, req1,
        output we0, we1,
        output addr0, addr1,
        output wdata0, wdata1,
        output memReadData,
        input  ack0, ack1,
        input  rdata0, rdata1,
        input  busy,
        input  memAddress, memWriteData,
        input  memRead, memWrite
    );

    modport slave (
        input  req0, req1,
        input  we0, we1,
        input  addr0, addr1,
        input  wdata0, wdata1,
        input  memReadData,
        output ack0, ack1,
        output rdata0, rdata1,
        output busy,
        output memAddress, memWriteData,
        output memRead, memWrite
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> COMPLETE per access.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin contention, else port 0 wins.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_t;

    state_t state;
    logic   op_we;
    logic   op_port;

    logic              any_req;
    logic              gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req = bus.req0 | bus.req1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last;

    always_comb begin
        gnt = ~bus.req0;
        if (bus.req0 && bus.req1) begin
            gnt = ~last;
        end
    end

    // Pointer follows every grant, contended or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last <= gnt;
        end
    end
`else
    always_comb begin
        gnt = ~bus.req0;
    end
`endif

    always_comb begin
        sel_we    = bus.we0;
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        if (gnt) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            op_we            <= 1'b0;
            op_port          <= 1'b0;
            bus.memRead      <= 1'b0;
            bus.memWrite     <= 1'b0;
            bus.ack0         <= 1'b0;
            bus.ack1         <= 1'b0;
            bus.busy         <= 1'b0;
            bus.memAddress   <= '0;
            bus.memWriteData <= '0;
            bus.rdata0       <= '0;
            bus.rdata1       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        op_we            <= sel_we;
                        op_port          <= gnt;
                        bus.memAddress   <= sel_addr;
                        bus.memWriteData <= sel_wdata;
                        bus.memRead      <= ~sel_we;
                        bus.memWrite     <= sel_we;
                        bus.busy         <= 1'b1;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory answers during the strobe cycle.
                    bus.memRead  <= 1'b0;
                    bus.memWrite <= 1'b0;
                    bus.ack0     <= ~op_port;
                    bus.ack1     <= op_port;
                    if (!op_we) begin
                        if (op_port) begin
                            bus.rdata1 <= bus.memReadData;
                        end else begin
                            bus.rdata0 <= bus.memReadData;
                        end
                    end
                    state <= COMPLETE;
                end
                COMPLETE: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: transaction-level model predicts grants and data,
// a negedge monitor checks strobes and acks against the queues.
module tb_dmem_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
    } ack_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [32];
    assign bus.memReadData = mem[bus.memAddress];
    always @(posedge clk) begin
        if (bus.memWrite) mem[bus.memAddress] <= bus.memWriteData;
    end

    int total = 0;
    int bad = 0;

    txn_t q0[$];
    txn_t q1[$];
    txn_t acc_q[$];
    ack_t ack_q[$];

    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_rd [2];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    int last = 1;
`endif

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last = 1;
`endif
    endtask

    task automatic push_txn(int p, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
        txn_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        if (p == 1) q1.push_back(t);
        else q0.push_back(t);
    endtask

    // Idle ports carry junk that the arbiter must ignore.
    task automatic drive();
        txn_t t;
        if (q0.size() > 0) begin
            t = q0[0];
            bus.req0 = 1'b1; bus.we0 = t.we; bus.addr0 = t.addr; bus.wdata0 = t.wdata;
        end else begin
            bus.req0 = 1'b0; bus.we0 = 1'($urandom);
            bus.addr0 = AW'($urandom); bus.wdata0 = DW'($urandom);
        end
        if (q1.size() > 0) begin
            t = q1[0];
            bus.req1 = 1'b1; bus.we1 = t.we; bus.addr1 = t.addr; bus.wdata1 = t.wdata;
        end else begin
            bus.req1 = 1'b0; bus.we1 = 1'($urandom);
            bus.addr1 = AW'($urandom); bus.wdata1 = DW'($urandom);
        end
    endtask

    // Called one time unit after an edge with the arbiter idle.
    task automatic step();
        int w;
        int n;
        txn_t t;
        ack_t k;
        if (q0.size() == 0 && q1.size() == 0) begin
            @(posedge clk); #1;
            return;
        end
        if (q0.size() > 0 && q1.size() > 0) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            w = (last == 0) ? 1 : 0;
`else
            w = 0;
`endif
        end else begin
            w = (q0.size() > 0) ? 0 : 1;
        end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last = w;
`endif
        t = (w == 1) ? q1[0] : q0[0];
        if (t.we) ref_mem[t.addr] = t.wdata;
        else exp_rd[w] = ref_mem[t.addr];
        acc_q.push_back(t);
        k.port = w;
        k.addr = t.addr;
        k.rd0 = exp_rd[0];
        k.rd1 = exp_rd[1];
        ack_q.push_back(k);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!((w == 1) ? bus.ack1 : bus.ack0) && n < 8);
        chk("ack_latency", n, 2);
        if (w == 1) void'(q1.pop_front());
        else void'(q0.pop_front());
        drive();
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        txn_t a;
        ack_t k;
        if (!rst) begin
            if (bus.memRead || bus.memWrite) begin
                chk("strobe_exclusive", {31'd0, bus.memRead & bus.memWrite}, 0);
                chk("busy_in_access", bus.busy, 1);
                if (acc_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    a = acc_q.pop_front();
                    chk("mem_write_strobe", bus.memWrite, a.we);
                    chk("mem_address", bus.memAddress, a.addr);
                    if (a.we) chk("mem_write_data", bus.memWriteData, a.wdata);
                end
            end
            if (bus.ack0 || bus.ack1) begin
                chk("acks_exclusive", {31'd0, bus.ack0 & bus.ack1}, 0);
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    k = ack_q.pop_front();
                    chk("ack_port", bus.ack1, (k.port == 1) ? 1 : 0);
                    chk("rdata0", bus.rdata0, k.rd0);
                    chk("rdata1", bus.rdata1, k.rd1);
                    chk("addr_stable", bus.memAddress, k.addr);
                    chk("strobes_low_complete", {bus.memRead, bus.memWrite}, 0);
                end
            end
        end
    end

    function automatic logic [DW-1:0] fill(int i);
        if (i == 0) return 8'h99;
        if (i == 25) return 8'h01;
        return DW'(i * 37 + 11);
    endfunction

    initial begin
        model_reset();
        drive();
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_memRead", bus.memRead, 0);
        chk("rst_memWrite", bus.memWrite, 0);
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_memAddress", bus.memAddress, 0);
        chk("rst_memWriteData", bus.memWriteData, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            push_txn(i % 2, 1'b1, AW'(i), fill(i));
            drive();
            step();
        end

        push_txn(0, 1'b1, 5'd5, 8'h2A);
        drive(); step();
        push_txn(1, 1'b0, 5'd25, 8'h00);
        drive(); step();
        push_txn(0, 1'b0, 5'd0, 8'h00);
        drive(); step();

        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd9; bus.wdata0 = 8'h55;
        @(posedge clk); #1;
        chk("pre_rst_memWrite", bus.memWrite, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_memWrite", bus.memWrite, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_ack0", bus.ack0, 0);
        chk("async_rst_memAddress", bus.memAddress, 0);
        chk("async_rst_rdata0", bus.rdata0, 0);
        @(posedge clk); #1;
        chk("rst_hold_ack0", bus.ack0, 0);
        rst = 1'b0;
        model_reset();
        push_txn(0, 1'b1, 5'd9, 8'h55);
        drive(); step();
        push_txn(0, 1'b0, 5'd9, 8'h00);
        drive(); step();

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            push_txn(0, 1'b0, AW'($urandom), 8'h00);
            push_txn(1, 1'b0, AW'($urandom), 8'h00);
        end
        drive();
        for (int i = 0; i < 20; i++) begin
            if (q0.size() > 0 || q1.size() > 0) step();
        end

        for (int i = 0; i < 300; i++) begin
            if (q0.size() < 2 && $urandom_range(2, 0) == 0)
                push_txn(0, 1'($urandom), AW'($urandom), DW'($urandom));
            if (q1.size() < 2 && $urandom_range(2, 0) == 0)
                push_txn(1, 1'($urandom), AW'($urandom), DW'($urandom));
            drive();
            step();
        end
        for (int i = 0; i < 20; i++) begin
            if (q0.size() > 0 || q1.size() > 0) step();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("acc_queue_drained", acc_q.size(), 0);
        chk("ack_queue_drained", ack_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
